// File: rtl/can_defs.sv
// rtl/can_defs.sv - shared CAN frame, status and scheduler state definitions
package can_defs;

  localparam int CAN_ARB_KEY_W = 30;

  typedef struct packed {
    logic [10:0]     id_std;
    logic [17:0]     id_ext;
    logic            ide;
    logic            rtr1;
    logic            rtr2;
    logic [3:0]      dlc;
    logic [14:0]     crc;
    logic [0:7][7:0] data;
  } can_frame_t;

  typedef enum logic {TXS_OK, TXS_FAIL} tx_status_e;

  typedef enum logic [2:0] {IDLE, SELECT, START, ACTIVE, COMPLETE} sched_state_e;

  // Lower key wins bus arbitration; base IDs compare ahead of extended ones with equal base.
  function automatic logic [CAN_ARB_KEY_W-1:0] arb_key(input can_frame_t f);
    return {f.id_std, f.ide, (f.ide ? f.id_ext : 18'h0)};
  endfunction

endpackage

// File: rtl/can_prio_select.sv
// rtl/can_prio_select.sv - combinational lowest-key search over a masked key set
module can_prio_select import can_defs::*; #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0][CAN_ARB_KEY_W-1:0] keys,
  input  logic [N-1:0]                    valid,
  output logic [IW-1:0]                   win_idx,
  output logic                            found
);

  logic [CAN_ARB_KEY_W-1:0] best;

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    best    = '1;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!found || keys[i] < best)) begin
        found   = 1'b1;
        best    = keys[i];
        win_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - mailbox transmit scheduler in front of can_transmitter
module can_tx_scheduler import can_defs::*; #(
  parameter  int NUM_MB      = 4,
  parameter  int RETRY_LIMIT = 8,
  localparam int IW          = $clog2(NUM_MB)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_point,
  input  logic                 load_valid,
  input  logic [IW-1:0]        load_idx,
  input  can_frame_t           load_frame,
  input  logic                 load_remote,
  output logic                 load_err,
  input  logic [NUM_MB-1:0]    abort_req,
  output logic [NUM_MB-1:0]    mb_pending,
  output logic                 start_tx,
  output logic                 tx_remote_req,
  output logic [10:0]          tx_id_std,
  output logic [17:0]          tx_id_ext,
  output logic                 tx_ide,
  output logic                 tx_rtr1,
  output logic                 tx_rtr2,
  output logic [3:0]           tx_dlc,
  output logic [14:0]          tx_crc,
  output logic [0:7][7:0]      tx_data,
  input  logic                 tx_done,
  input  logic                 arb_lost,
  output logic                 tx_abort,
  output logic                 done_pulse,
  output logic                 fail_pulse,
  output logic [IW-1:0]        done_idx,
  output logic                 busy
);

  localparam int              RW        = (RETRY_LIMIT == 0) ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam logic [RW-1:0]   RETRY_MAX = RW'(RETRY_LIMIT);

  can_frame_t                           mb_frame [NUM_MB];
  logic [NUM_MB-1:0]                    mb_remote;
  logic [NUM_MB-1:0][CAN_ARB_KEY_W-1:0] keys;
  sched_state_e                         state, state_nxt;
  can_frame_t                           sh_frame;
  logic                                 sh_remote;
  logic [IW-1:0]                        act_idx;
  logic [RW-1:0]                        retry_cnt, retry_inc;
  tx_status_e                           status;
  logic [IW-1:0]                        sel_idx, abort_idx;
  logic                                 sel_found, abort_found;
  logic [NUM_MB-1:0]                    cand, act_oh, abort_mask;
  logic                                 sp_done, sp_lost, arb_fail;

  always_comb begin
    for (int i = 0; i < NUM_MB; i++) keys[i] = arb_key(mb_frame[i]);
  end

  assign cand = mb_pending & ~abort_req;

  can_prio_select #(.N(NUM_MB)) u_sel (
    .keys    (keys),
    .valid   (cand),
    .win_idx (sel_idx),
    .found   (sel_found)
  );

  // The shadowed mailbox is owned by the frame sequence until COMPLETE releases it.
  assign act_oh     = (state == START || state == ACTIVE || state == COMPLETE)
                      ? (NUM_MB'(1) << act_idx) : '0;
  assign abort_mask = mb_pending & abort_req & ~act_oh;

  always_comb begin
    abort_found = 1'b0;
    abort_idx   = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (abort_mask[i] && !abort_found) begin
        abort_found = 1'b1;
        abort_idx   = IW'(i);
      end
    end
  end

  assign sp_done   = sample_point & tx_done;
  assign sp_lost   = sample_point & arb_lost & ~tx_done;
  assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
  assign arb_fail  = abort_req[act_idx] || (RETRY_LIMIT != 0 && retry_inc == RETRY_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (|cand) state_nxt = SELECT;
      SELECT:   state_nxt = sel_found ? START : IDLE;
      START:    if (sample_point) state_nxt = ACTIVE;
      ACTIVE: begin
        if (sp_done)      state_nxt = COMPLETE;
        else if (sp_lost) state_nxt = arb_fail ? COMPLETE : IDLE;
      end
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign start_tx = (state == START);
  assign busy     = (state != IDLE);
  assign tx_abort = (state == ACTIVE) && sp_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (load_valid && !mb_pending[load_idx]) mb_frame[load_idx] <= load_frame;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_pending <= '0;
      mb_remote  <= '0;
      sh_frame   <= '0;
      sh_remote  <= 1'b0;
      act_idx    <= '0;
      retry_cnt  <= '0;
      status     <= TXS_OK;
      load_err   <= 1'b0;
      done_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      done_idx   <= '0;
    end else begin
      load_err   <= 1'b0;
      done_pulse <= 1'b0;
      fail_pulse <= 1'b0;

      if (load_valid) begin
        if (mb_pending[load_idx]) begin
          load_err <= 1'b1;
        end else begin
          mb_pending[load_idx] <= 1'b1;
          mb_remote[load_idx]  <= load_remote;
        end
      end

      if (state == SELECT && sel_found) begin
        sh_frame  <= mb_frame[sel_idx];
        sh_remote <= mb_remote[sel_idx];
        act_idx   <= sel_idx;
        if (sel_idx != act_idx) retry_cnt <= '0;
      end

      if (state == ACTIVE && sp_done) begin
        status <= TXS_OK;
      end else if (state == ACTIVE && sp_lost) begin
        retry_cnt <= retry_inc;
        status    <= arb_fail ? TXS_FAIL : TXS_OK;
      end

      // Completion outranks a host abort in the same cycle; the abort stays visible next cycle.
      if (state == COMPLETE) begin
        mb_pending[act_idx] <= 1'b0;
        done_idx            <= act_idx;
        done_pulse          <= (status == TXS_OK);
        fail_pulse          <= (status == TXS_FAIL);
        retry_cnt           <= '0;
      end else if (abort_found) begin
        mb_pending[abort_idx] <= 1'b0;
        done_idx              <= abort_idx;
        fail_pulse            <= 1'b1;
      end
    end
  end

  assign tx_remote_req = sh_remote;
  assign tx_id_std     = sh_frame.id_std;
  assign tx_id_ext     = sh_frame.id_ext;
  assign tx_ide        = sh_frame.ide;
  assign tx_rtr1       = sh_frame.rtr1;
  assign tx_rtr2       = sh_frame.rtr2;
  assign tx_dlc        = sh_frame.dlc;
  assign tx_crc        = sh_frame.crc;
  assign tx_data       = sh_frame.data;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - directed self-checking bench for can_tx_scheduler
module tb_can_tx_scheduler;
  import can_defs::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_point = 1'b0;
  logic            load_valid = 1'b0;
  logic [1:0]      load_idx = '0;
  can_frame_t      load_frame = '0;
  logic            load_remote = 1'b0;
  logic [3:0]      abort_req = '0;
  logic            tx_done = 1'b0;
  logic            arb_lost = 1'b0;
  logic            load_err, start_tx, tx_remote_req, tx_ide, tx_rtr1, tx_rtr2;
  logic [3:0]      mb_pending;
  logic [10:0]     tx_id_std;
  logic [17:0]     tx_id_ext;
  logic [3:0]      tx_dlc;
  logic [14:0]     tx_crc;
  logic [0:7][7:0] tx_data;
  logic            tx_abort, done_pulse, fail_pulse, busy;
  logic [1:0]      done_idx;

  int n_vec = 0;
  int n_err = 0;
  logic seen;

  always #5 clk = ~clk;

  can_tx_scheduler #(.NUM_MB(4), .RETRY_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .sample_point(sample_point),
    .load_valid(load_valid), .load_idx(load_idx), .load_frame(load_frame),
    .load_remote(load_remote), .load_err(load_err), .abort_req(abort_req),
    .mb_pending(mb_pending), .start_tx(start_tx), .tx_remote_req(tx_remote_req),
    .tx_id_std(tx_id_std), .tx_id_ext(tx_id_ext), .tx_ide(tx_ide),
    .tx_rtr1(tx_rtr1), .tx_rtr2(tx_rtr2), .tx_dlc(tx_dlc), .tx_crc(tx_crc),
    .tx_data(tx_data), .tx_done(tx_done), .arb_lost(arb_lost),
    .tx_abort(tx_abort), .done_pulse(done_pulse), .fail_pulse(fail_pulse),
    .done_idx(done_idx), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [10:0] id, input logic [3:0] dlc, input logic rem);
    load_frame         = '0;
    load_frame.id_std  = id;
    load_frame.dlc     = dlc;
    load_frame.data[0] = 8'hA5;
    load_idx           = 2'(idx);
    load_remote        = rem;
    load_valid         = 1'b1;
    tick();
    load_valid  = 1'b0;
    load_remote = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start_tx && n < 20) begin
      tick();
      n++;
    end
    chk(tag, start_tx, 1);
  endtask

  task automatic pulse_sp(input logic d, input logic l);
    sample_point = 1'b1;
    tx_done      = d;
    arb_lost     = l;
    #1;
    if (l) chk("tx_abort_on_lost", tx_abort, !d);
    tick();
    sample_point = 1'b0;
    tx_done      = 1'b0;
    arb_lost     = 1'b0;
  endtask

  task automatic send(input string tag, input logic [1:0] idx, input logic [10:0] id);
    wait_start({tag, "_start"});
    chk({tag, "_id"}, tx_id_std, id);
    pulse_sp(1'b0, 1'b0);
    pulse_sp(1'b1, 1'b0);
    tick();
    chk({tag, "_done"}, {done_pulse, fail_pulse, done_idx}, {2'b10, idx});
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_flags", {start_tx, busy, tx_abort, done_pulse, fail_pulse, load_err, tx_remote_req}, 0);
    chk("rst_pending", mb_pending, 0);
    chk("rst_shadow", tx_id_std, 0);
    rst_n = 1'b1;
    tick();

    // Single frame on MB0
    load(0, 11'h123, 4'd2, 1'b0);
    chk("t1_pending", mb_pending, 4'b0001);
    wait_start("t1_start");
    chk("t1_id", tx_id_std, 11'h123);
    chk("t1_dlc", tx_dlc, 4'd2);
    chk("t1_data0", tx_data[0], 8'hA5);
    tick();
    chk("t1_start_hold", start_tx, 1);
    pulse_sp(1'b0, 1'b0);
    chk("t1_start_drop", start_tx, 0);
    pulse_sp(1'b1, 1'b0);
    tick();
    chk("t1_done", {done_pulse, fail_pulse, done_idx}, 4'b1000);
    chk("t1_pending_clr", mb_pending, 0);
    tick();
    chk("t1_done_once", done_pulse, 0);

    // Priority order and tie break
    load(3, 11'h100, 4'd1, 1'b0);
    load(2, 11'h100, 4'd1, 1'b0);
    load(0, 11'h400, 4'd1, 1'b0);
    chk("t2_pending", mb_pending, 4'b1101);
    send("t2_first", 2'd2, 11'h100);
    send("t2_second", 2'd3, 11'h100);
    send("t2_third", 2'd0, 11'h400);
    chk("t2_pending_clr", mb_pending, 0);

    // Retry limit of 2
    load(1, 11'h055, 4'd0, 1'b0);
    wait_start("t3_start");
    pulse_sp(1'b0, 1'b0);
    pulse_sp(1'b0, 1'b1);
    chk("t3_abort_single", tx_abort, 0);
    chk("t3_retry_idle", {busy, fail_pulse, mb_pending}, 6'b000010);
    wait_start("t3_restart");
    pulse_sp(1'b0, 1'b0);
    pulse_sp(1'b0, 1'b1);
    tick();
    chk("t3_fail", {done_pulse, fail_pulse, done_idx}, 4'b0101);
    chk("t3_pending_clr", mb_pending, 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | start_tx;
    end
    chk("t3_no_third_start", seen, 0);

    // Abort of a pending mailbox while MB0 is active
    load(0, 11'h010, 4'd1, 1'b0);
    load(1, 11'h200, 4'd1, 1'b0);
    wait_start("t4_start");
    chk("t4_id", tx_id_std, 11'h010);
    pulse_sp(1'b0, 1'b0);
    abort_req = 4'b0011;
    tick();
    chk("t4_abort_pulse", {fail_pulse, done_pulse, done_idx}, 4'b1001);
    chk("t4_pending", {busy, mb_pending}, 5'b10001);
    abort_req = 4'b0001;
    tick();
    chk("t4_abort_once", fail_pulse, 0);
    pulse_sp(1'b1, 1'b0);
    tick();
    chk("t4_active_ok", {done_pulse, fail_pulse, done_idx}, 4'b1000);
    abort_req = 4'b0000;
    chk("t4_pending_clr", mb_pending, 0);

    // Load to the active mailbox is rejected
    load(0, 11'h321, 4'd3, 1'b1);
    wait_start("t5_start");
    chk("t5_remote", tx_remote_req, 1);
    pulse_sp(1'b0, 1'b0);
    load(0, 11'h7FF, 4'd1, 1'b0);
    chk("t5_load_err", load_err, 1);
    chk("t5_shadow_kept", tx_id_std, 11'h321);
    tick();
    chk("t5_load_err_once", load_err, 0);

    // Asynchronous reset mid-frame
    chk("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {start_tx, busy, tx_abort, done_pulse, fail_pulse, load_err, tx_remote_req}, 0);
    chk("t6_rst_pending", mb_pending, 0);
    chk("t6_rst_shadow", {tx_id_std, tx_dlc}, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | busy | done_pulse | fail_pulse | start_tx;
    end
    chk("t6_quiet_after", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Mailbox-based transmit scheduler that sits in front of can_transmitter.
- Holds NUM_MB transmit mailboxes loaded by the host side.
- Picks the pending mailbox with the highest CAN priority (lowest arbitration key), latches it into a shadow frame, and sequences start_tx and completion.
- Handles arbitration-loss retries, retry-limit failure, and host aborts.

Parameters:
- NUM_MB, 4, number of transmit mailboxes (2..8).
- RETRY_LIMIT, 8, arbitration-loss retries before a mailbox is failed; 0 means unlimited.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_point  in  1  bit-timing strobe, same one that drives can_transmitter
- load_valid  in  1  host writes load_frame into mailbox load_idx
- load_idx  in  $clog2(NUM_MB)  target mailbox
- load_frame  in  can_frame_t  id_std, id_ext, ide, rtr1, rtr2, dlc, crc, data[0:7]
- load_remote  in  1  remote-request flag for the loaded frame
- load_err  out  1  one-cycle pulse: load rejected because the target mailbox is pending
- abort_req  in  NUM_MB  per-mailbox abort request, level; sampled every clk
- mb_pending  out  NUM_MB  mailbox holds a frame awaiting or in transmission
- start_tx  out  1  to transmitter
- tx_remote_req  out  1  to transmitter, from shadow
- tx_id_std, tx_id_ext, tx_ide, tx_rtr1, tx_rtr2, tx_dlc, tx_crc, tx_data[0:7]  out  per can_frame_t  shadow frame to transmitter
- tx_done  in  1  from transmitter, valid in the sample_point cycle
- arb_lost  in  1  one-cycle pulse from the bus monitor, valid in a sample_point cycle
- tx_abort  out  1  one-cycle pulse returning the transmitter to idle after arbitration loss
- done_pulse  out  1  one-cycle: mailbox done_idx sent successfully
- fail_pulse  out  1  one-cycle: mailbox done_idx aborted or retry limit hit
- done_idx  out  $clog2(NUM_MB)  mailbox index for done_pulse/fail_pulse
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - all outputs 0; mb_pending 0; shadow frame 0; retry counter 0; FSM IDLE.
  - Reset mid-frame discards everything, with no pulses.
- Load:
  - load_valid to a non-pending mailbox writes the frame and sets pending next clk.
  - load_valid to a pending mailbox (including the active one) is ignored and pulses load_err the next clk.
- Arbitration key: {id_std, ide, ide ? id_ext : 18'h0}, 30 bits. Lowest key wins; ties go to the lowest index.
- FSM states, advancing on clk unless noted:
  - IDLE: if any mb_pending and no abort_req on it, go to SELECT.
  - SELECT (1 clk):
    - Combinational min-search over pending, non-aborted mailboxes.
    - Latch the winning frame, remote flag and index into the shadow registers, then go to START.
    - If no candidate remains, return to IDLE.
  - START:
    - Hold start_tx=1.
    - On the first clk with sample_point=1, go to ACTIVE. start_tx drops the following clk, so it is high across exactly one sample_point.
  - ACTIVE:
    - Shadow outputs stay stable; load_* to other mailboxes is allowed.
    - tx_done & sample_point goes to COMPLETE (status ok).
    - arb_lost & sample_point pulses tx_abort (same cycle, combinational) and increments retry_cnt.
      - If RETRY_LIMIT != 0 and the new count equals RETRY_LIMIT, go to COMPLETE (status fail).
      - Otherwise go to IDLE for re-selection; a newly loaded higher-priority mailbox may now win.
  - COMPLETE (1 clk):
    - Clear mb_pending[done_idx] and pulse done_pulse or fail_pulse.
    - Clear retry_cnt, then go to IDLE.
- retry_cnt:
  - Belongs to the mailbox in the shadow; cleared when a different mailbox is selected.
  - Width $clog2(RETRY_LIMIT+1), saturating.
- Abort:
  - abort_req on a pending, non-active mailbox clears pending the next clk and pulses fail_pulse with that index.
  - Only one abort completes per clk, lowest index first.
  - abort_req on the active mailbox in START/ACTIVE does not interrupt the frame. On tx_done it completes as ok (the frame was sent). On arb_lost it completes as fail without retry.
- Simultaneous events:
  - A COMPLETE pulse has priority over an abort pulse in the same clk; the abort is handled the next clk.
  - tx_done and arb_lost together: tx_done wins.
- The FSM never reaches START with an empty mailbox, so start_tx is never asserted for an empty mailbox.

Decomposition:
- can_defs package holds the shared definitions:
  - can_frame_t (reused from can_defs)
  - tx_status_e {TXS_OK, TXS_FAIL}
  - sched_state_e {IDLE, SELECT, START, ACTIVE, COMPLETE}
  - CAN_ARB_KEY_W = 30
- One sub-module, can_prio_select:
  - purely combinational min-key search over NUM_MB keys with a valid mask.
  - Outputs winner index and found flag.

Test Plan:
- Load MB0 id_std=0x123, dlc=2 → one start_tx sample_point; tx_done → done_pulse with done_idx=0; mb_pending=0000.
- Load MB0 id=0x400, MB2 id=0x100, MB3 id=0x100 → MB2 sent first, then MB3 (tie broken by lower index), then MB0.
- RETRY_LIMIT=2, MB1 pending, two arb_lost pulses → two tx_abort pulses; the second gives fail_pulse with done_idx=1; no third start_tx.
- During MB0 ACTIVE, assert abort_req[0] and abort_req[1] (MB1 pending) → fail_pulse idx=1 at once; MB0 completes as ok on tx_done.
- load_valid to active MB0 → load_err pulse; shadow tx_id_std unchanged.
- Assert rst_n=0 during ACTIVE → all outputs 0 asynchronously; after release, busy=0 and no pulses.
